// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Multi-channel memory responder. Each channel accepts one read or write
// request at a time and answers it LATENCY cycles later. It then holds the
// response until the requester drops its valid (four-phase handshake).
// Storage is a single shared array. It can also be preloaded through a
// backdoor load port that works regardless of channel activity.
//
// Parameters
//   ADDR_BITS    address width; storage holds 2**ADDR_BITS words
//   DATA_BITS    word width
//   CHANNELS     number of independent request channels
//   LATENCY      cycles from request acceptance to ready (1..15)
//   WRITE_ENABLE 0 = write requests are never accepted
//
// Ports
//   clk            clock; all state updates on its rising edge
//   reset          asynchronous, active-high reset
//   read_valid     per-channel read request
//   read_address   per-channel read address, channel c at [c*ADDR_BITS +: ADDR_BITS]
//   read_ready     per-channel read response valid
//   read_data      per-channel read data, channel c at [c*DATA_BITS +: DATA_BITS]
//   write_valid    per-channel write request
//   write_address  per-channel write address
//   write_data     per-channel write data
//   write_ready    per-channel write completion
//   load_en        backdoor preload strobe
//   load_addr      backdoor preload address
//   load_data      backdoor preload data
//   protocol_err   (only with MEM_RESPONDER_PROTOCOL_CHECK_EN) sticky flag
//                  for a dropped valid or a changed address mid-transaction
//
// Optional feature macro: MEM_RESPONDER_PROTOCOL_CHECK_EN
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int CHANNELS     = 4,
  parameter int LATENCY      = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            read_valid,
  input  logic [CHANNELS*ADDR_BITS-1:0]  read_address,
  output logic [CHANNELS-1:0]            read_ready,
  output logic [CHANNELS*DATA_BITS-1:0]  read_data,
  input  logic [CHANNELS-1:0]            write_valid,
  input  logic [CHANNELS*ADDR_BITS-1:0]  write_address,
  input  logic [CHANNELS*DATA_BITS-1:0]  write_data,
  output logic [CHANNELS-1:0]            write_ready,
  input  logic                           load_en,
  input  logic [ADDR_BITS-1:0]           load_addr,
  input  logic [DATA_BITS-1:0]           load_data
`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
  ,
  output logic                           protocol_err
`endif
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_RD,
    BUSY_WR,
    RESP_RD,
    RESP_WR
  } state_e;

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  // Per-channel write commit request, collected for the shared storage port.
  logic [CHANNELS-1:0]  wr_commit;
  logic [ADDR_BITS-1:0] ch_addr  [CHANNELS];
  logic [DATA_BITS-1:0] ch_wdata [CHANNELS];

`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
  logic [CHANNELS-1:0] err_hit;
`endif

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  // NOTE: the memory array has no reset; contents survive reset and are
  // defined only by load_en or committed writes.
  // The load is issued first and the channels from highest to lowest index.
  // The last non-blocking write to an address wins, so channel writes beat
  // the load and the lowest channel beats the others.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (wr_commit[c]) begin
        mem_q[ch_addr[c]] <= ch_wdata[c];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel request FSMs
  // -------------------------------------------------------------------------
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic                 rd_v;
    logic                 wr_v;
    logic [ADDR_BITS-1:0] rd_a;
    logic [ADDR_BITS-1:0] wr_a;
    logic [DATA_BITS-1:0] wr_d;

    state_e               state_q,  state_d;
    logic [3:0]           cnt_q,    cnt_d;
    logic [ADDR_BITS-1:0] addr_q,   addr_d;
    logic [DATA_BITS-1:0] wdata_q,  wdata_d;
    logic [DATA_BITS-1:0] rdata_q,  rdata_d;
    logic                 rready_q, rready_d;
    logic                 wready_q, wready_d;

    assign rd_v = read_valid[c];
    assign wr_v = write_valid[c];
    assign rd_a = read_address[c*ADDR_BITS +: ADDR_BITS];
    assign wr_a = write_address[c*ADDR_BITS +: ADDR_BITS];
    assign wr_d = write_data[c*DATA_BITS +: DATA_BITS];

    // NOTE: state registers use non-blocking assignments so every channel
    // and the storage see the same pre-edge values on a given edge.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        addr_q   <= '0;
        wdata_q  <= '0;
        rdata_q  <= '0;
        rready_q <= 1'b0;
        wready_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        rdata_q  <= rdata_d;
        rready_q <= rready_d;
        wready_q <= wready_d;
      end
    end

    // NOTE: every signal written here gets a hold default first, so no
    // branch can leave one unassigned and infer a latch.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      rready_d = rready_q;
      wready_d = wready_q;

      case (state_q)
        IDLE: begin
          // Read takes priority over write on the same cycle.
          if (rd_v) begin
            state_d = BUSY_RD;
            addr_d  = rd_a;
            cnt_d   = CNT_LOAD;
          end else if (wr_v && (WRITE_ENABLE != 0)) begin
            state_d = BUSY_WR;
            addr_d  = wr_a;
            wdata_d = wr_d;
            cnt_d   = CNT_LOAD;
          end
        end
        BUSY_RD: begin
          if (cnt_q == 4'd0) begin
            // Reads the pre-edge storage, so a write committing on this same
            // edge to this address is not yet visible.
            state_d  = RESP_RD;
            rdata_d  = mem_q[addr_q];
            rready_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        BUSY_WR: begin
          if (cnt_q == 4'd0) begin
            state_d  = RESP_WR;
            wready_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        RESP_RD: begin
          if (!rd_v) begin
            state_d  = IDLE;
            rready_d = 1'b0;
          end
        end
        RESP_WR: begin
          if (!wr_v) begin
            state_d  = IDLE;
            wready_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    assign wr_commit[c] = (state_q == BUSY_WR) && (cnt_q == 4'd0);
    assign ch_addr[c]   = addr_q;
    assign ch_wdata[c]  = wdata_q;

    assign read_ready[c]                         = rready_q;
    assign write_ready[c]                        = wready_q;
    assign read_data[c*DATA_BITS +: DATA_BITS]   = rdata_q;

`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
    // Valid must stay high while busy. The address must stay stable while
    // the request is held. Once valid drops in RESP, the address is free.
    assign err_hit[c] =
        ((state_q == BUSY_RD) && (!rd_v || (rd_a != addr_q))) ||
        ((state_q == BUSY_WR) && (!wr_v || (wr_a != addr_q))) ||
        ((state_q == RESP_RD) && rd_v && (rd_a != addr_q))    ||
        ((state_q == RESP_WR) && wr_v && (wr_a != addr_q));
`endif
  end

`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (|err_hit) begin
      err_q <= 1'b1;
    end
  end

  assign protocol_err = err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//
// Directed bench for mem_responder with default parameters. It also drives a
// second instance with WRITE_ENABLE=0 from the same inputs. Expected read
// data goes into a scoreboard queue when a request is driven. Each entry is
// popped and compared when the DUT raises read_ready.
// ---------------------------------------------------------------------------
module tb_mem_responder;

  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int CH  = 4;
  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH-1:0]     read_valid;
  logic [CH*AB-1:0]  read_address;
  logic [CH-1:0]     read_ready;
  logic [CH*DB-1:0]  read_data;
  logic [CH-1:0]     write_valid;
  logic [CH*AB-1:0]  write_address;
  logic [CH*DB-1:0]  write_data;
  logic [CH-1:0]     write_ready;
  logic              load_en;
  logic [AB-1:0]     load_addr;
  logic [DB-1:0]     load_data;

  logic [CH-1:0]     nw_read_ready;
  logic [CH*DB-1:0]  nw_read_data;
  logic [CH-1:0]     nw_write_ready;

`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
  logic              protocol_err;
  logic              nw_protocol_err;
`endif

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .CHANNELS(CH), .LATENCY(LAT), .WRITE_ENABLE(1)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .read_valid   (read_valid),
    .read_address (read_address),
    .read_ready   (read_ready),
    .read_data    (read_data),
    .write_valid  (write_valid),
    .write_address(write_address),
    .write_data   (write_data),
    .write_ready  (write_ready),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data)
`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
    ,
    .protocol_err (protocol_err)
`endif
  );

  mem_responder #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .CHANNELS(CH), .LATENCY(LAT), .WRITE_ENABLE(0)
  ) u_dut_nw (
    .clk          (clk),
    .reset        (reset),
    .read_valid   (read_valid),
    .read_address (read_address),
    .read_ready   (nw_read_ready),
    .read_data    (nw_read_data),
    .write_valid  (write_valid),
    .write_address(write_address),
    .write_data   (write_data),
    .write_ready  (nw_write_ready),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data)
`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
    ,
    .protocol_err (nw_protocol_err)
`endif
  );

  typedef struct {
    int            ch;
    logic [DB-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   test_cnt = 0;
  int   fail_cnt = 0;
  bit   nw_wr_seen = 1'b0;

  // Sticky record of any write completion from the write-disabled instance.
  always @(posedge clk) begin
    if (nw_write_ready !== '0) nw_wr_seen = 1'b1;
  end

  // Watchdog: the bench never hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int c, input logic v, input logic [AB-1:0] a);
    read_valid[c]          = v;
    read_address[c*AB +: AB] = a;
  endtask

  task automatic set_wr(input int c, input logic v, input logic [AB-1:0] a, input logic [DB-1:0] d);
    write_valid[c]            = v;
    write_address[c*AB +: AB] = a;
    write_data[c*DB +: DB]    = d;
  endtask

  task automatic do_load(input logic [AB-1:0] a, input logic [DB-1:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic push_exp(input int c, input logic [DB-1:0] d);
    exp_t e;
    e.ch   = c;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    check({tag, " sb nonempty"}, 64'(sb_q.size() != 0), 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check({tag, " ready"}, read_ready[e.ch], 1'b1);
    check({tag, " data"}, read_data[e.ch*DB +: DB], e.data);
  endtask

  // Count the edges from driving the request until read_ready[c] rises.
  task automatic wait_rd(input int c, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!read_ready[c] && n < 20);
  endtask

  // One full read handshake: request, check latency/data, hold, release.
  task automatic read_txn(input int c, input logic [AB-1:0] a, input logic [DB-1:0] d,
                          input string tag);
    int n;
    push_exp(c, d);
    set_rd(c, 1'b1, a);
    wait_rd(c, n);
    check({tag, " latency"}, n, LAT + 1);
    pop_cmp(tag);
    tick();
    tick();
    check({tag, " hold ready"}, read_ready[c], 1'b1);
    check({tag, " hold data"}, read_data[c*DB +: DB], d);
    set_rd(c, 1'b0, a);
    tick();
    check({tag, " release"}, read_ready[c], 1'b0);
  endtask

  task automatic write_txn(input int c, input logic [AB-1:0] a, input logic [DB-1:0] d,
                           input string tag);
    int n = 0;
    set_wr(c, 1'b1, a, d);
    do begin
      tick();
      n++;
    end while (!write_ready[c] && n < 20);
    check({tag, " wr latency"}, n, LAT + 1);
    check({tag, " nw write_ready"}, nw_write_ready, '0);
    tick();
    check({tag, " wr hold"}, write_ready[c], 1'b1);
    set_wr(c, 1'b0, a, d);
    tick();
    check({tag, " wr release"}, write_ready[c], 1'b0);
  endtask

  initial begin
    int n;

    reset         = 1'b1;
    read_valid    = '0;
    read_address  = '0;
    write_valid   = '0;
    write_address = '0;
    write_data    = '0;
    load_en       = 1'b0;
    load_addr     = '0;
    load_data     = '0;

    // Reset state
    tick();
    tick();
    check("rst read_ready", read_ready, '0);
    check("rst write_ready", write_ready, '0);
    check("rst read_data", read_data, '0);
    check("rst nw outputs", {nw_read_ready, nw_read_data}, '0);
`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
    check("rst protocol_err", protocol_err, 1'b0);
`endif
    reset = 1'b0;
    tick();

    // Preload, then a ch0 read with exact latency and four-phase hold.
    do_load(8'h10, 8'h5A);
    read_txn(0, 8'h10, 8'h5A, "ch0 rd 0x10");

    // ch1 write, then ch2 reads it back. The write-disabled copy stays silent.
    write_txn(1, 8'h20, 8'hC3, "ch1 wr 0x20");
    read_txn(2, 8'h20, 8'hC3, "ch2 rd 0x20");

    // Same-edge writes to one address: the lowest channel wins.
    set_wr(0, 1'b1, 8'h30, 8'h11);
    set_wr(3, 1'b1, 8'h30, 8'h22);
    n = 0;
    do begin tick(); n++; end while (!write_ready[0] && n < 20);
    check("dual wr ready", write_ready, 4'b1001);
    set_wr(0, 1'b0, 8'h30, 8'h11);
    set_wr(3, 1'b0, 8'h30, 8'h22);
    tick();
    read_txn(1, 8'h30, 8'h11, "rd 0x30 after dual wr");

    // All four channels read at once.
    do_load(8'h00, 8'hA0);
    do_load(8'h01, 8'hB1);
    do_load(8'h02, 8'hC2);
    do_load(8'h03, 8'hD3);
    push_exp(0, 8'hA0);
    push_exp(1, 8'hB1);
    push_exp(2, 8'hC2);
    push_exp(3, 8'hD3);
    for (int c = 0; c < CH; c++) set_rd(c, 1'b1, AB'(c));
    wait_rd(0, n);
    check("quad rd latency", n, LAT + 1);
    check("quad rd all ready", read_ready, 4'hF);
    for (int c = 0; c < CH; c++) pop_cmp("quad rd");
    for (int c = 0; c < CH; c++) set_rd(c, 1'b0, AB'(c));
    tick();
    check("quad rd release", read_ready, '0);

    // A read committing on the same edge as a write to that address sees the old value.
    do_load(8'h50, 8'h01);
    push_exp(1, 8'h01);
    set_wr(0, 1'b1, 8'h50, 8'h02);
    set_rd(1, 1'b1, 8'h50);
    wait_rd(1, n);
    check("rd/wr same edge latency", n, LAT + 1);
    check("rd/wr same edge wr ready", write_ready[0], 1'b1);
    pop_cmp("rd/wr same edge");
    set_wr(0, 1'b0, 8'h50, 8'h02);
    set_rd(1, 1'b0, 8'h50);
    tick();
    read_txn(2, 8'h50, 8'h02, "rd 0x50 after wr");

    // A channel write beats a load to the same address on the same edge.
    set_wr(2, 1'b1, 8'h60, 8'hAA);
    tick();
    tick();
    load_en   = 1'b1;
    load_addr = 8'h60;
    load_data = 8'hBB;
    tick();
    load_en   = 1'b0;
    check("wr vs load ready", write_ready[2], 1'b1);
    set_wr(2, 1'b0, 8'h60, 8'hAA);
    tick();
    read_txn(0, 8'h60, 8'hAA, "rd 0x60 wr beats load");

    // A read is taken over a simultaneous write on the same channel.
    push_exp(3, 8'h5A);
    set_rd(3, 1'b1, 8'h10);
    set_wr(3, 1'b1, 8'h10, 8'hEE);
    wait_rd(3, n);
    check("rd priority latency", n, LAT + 1);
    check("rd priority no wr", write_ready[3], 1'b0);
    pop_cmp("rd priority");
    set_rd(3, 1'b0, 8'h10);
    set_wr(3, 1'b0, 8'h10, 8'hEE);
    tick();
    read_txn(3, 8'h10, 8'h5A, "rd 0x10 unchanged");

`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
    check("no false protocol_err", protocol_err, 1'b0);
`endif

    // Reset mid-transaction: ch1 holds a response, ch0 is busy writing.
    do_load(8'h40, 8'h77);
    push_exp(1, 8'hA0);
    set_rd(1, 1'b1, 8'h00);
    wait_rd(1, n);
    pop_cmp("pre-reset ch1 rd");
    set_wr(0, 1'b1, 8'h40, 8'h99);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("async rst read_ready", read_ready, '0);
    check("async rst write_ready", write_ready, '0);
    check("async rst read_data", read_data, '0);
    set_wr(0, 1'b0, 8'h40, 8'h99);
    set_rd(1, 1'b0, 8'h00);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("post rst write_ready", write_ready, '0);
    read_txn(0, 8'h40, 8'h77, "rd 0x40 write dropped");

    check("nw write_ready never set", nw_wr_seen, 1'b0);

`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
    // Dropping read_valid while busy sets the sticky error; only reset clears it.
    check("protocol_err before drop", protocol_err, 1'b0);
    set_rd(0, 1'b1, 8'h10);
    tick();
    set_rd(0, 1'b0, 8'h10);
    tick();
    check("protocol_err set", protocol_err, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    check("protocol_err sticky", protocol_err, 1'b1);
    reset = 1'b1;
    #1;
    check("protocol_err cleared", protocol_err, 1'b0);
    tick();
    reset = 1'b0;
    tick();
`endif

    check("scoreboard drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
